scan_chain_ctrl: RTL

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

---
 rtl/scan_chain_if.sv | 27 ++
 rtl/scan_chain_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/scan_chain_if.sv
// Handshake and chain-side signal bundle for scan_chain_ctrl.
// slave: the controller itself; master: the load producer / capture consumer / chain model.
interface scan_chain_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             abort;
  logic             scan_en;
  logic             scan_out;
  logic             scan_in;
  logic             update_en;
  logic             cap_valid;
  logic             cap_ready;
  logic [WIDTH-1:0] cap_data;

  modport slave (
    input  load_valid, load_data, abort, scan_in, cap_ready,
    output load_ready, scan_en, scan_out, update_en, cap_valid, cap_data
  );

  modport master (
    output load_valid, load_data, abort, scan_in, cap_ready,
    input  load_ready, scan_en, scan_out, update_en, cap_valid, cap_data
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shifts a parallel word into an external WIDTH-bit
// flip-flop chain (LSB first), captures what falls out of the chain tail,
// strobes update_en once, then presents the captured word on a valid/ready port.
module scan_chain_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  scan_chain_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] cap_data_q;
  logic [CW-1:0]    cnt;
  logic             last_shift;

  assign last_shift = (cnt == CW'(WIDTH - 1));

  // State register; reset forces IDLE without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort wins over the final-shift transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load_valid) state_nxt = SHIFT;
      SHIFT: begin
        if (bus.abort)       state_nxt = IDLE;
        else if (last_shift) state_nxt = UPDATE;
      end
      UPDATE:  state_nxt = RESP;
      RESP:    if (bus.cap_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load, shift with bit counter, and capture of the shifted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      cnt        <= '0;
      cap_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            shift_reg <= bus.load_data;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          shift_reg <= {bus.scan_in, shift_reg[WIDTH-1:1]};
          // Counter saturates at WIDTH-1 so it never leaves its legal range.
          if (!last_shift) cnt <= cnt + CW'(1);
        end
        UPDATE:  cap_data_q <= shift_reg;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers only; no input reaches an output.
  always_comb begin
    bus.load_ready = 1'b0;
    bus.scan_en    = 1'b0;
    bus.scan_out   = 1'b0;
    bus.update_en  = 1'b0;
    bus.cap_valid  = 1'b0;
    bus.cap_data   = cap_data_q;
    case (state)
      IDLE:   bus.load_ready = 1'b1;
      SHIFT: begin
        bus.scan_en  = 1'b1;
        bus.scan_out = shift_reg[0];
      end
      UPDATE: bus.update_en = 1'b1;
      RESP:   bus.cap_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
